// File: rtl/axi_read_intf.sv
// axi_read_intf
//   AXI4 read-channel slave for the fifo/iram/wram region map. Accepts one
//   AR burst at a time and turns it into single-beat internal reads. Each read
//   returns data exactly one cycle after its strobe. The returned data goes
//   back on the R channel through a 2-entry FIFO, so RREADY backpressure
//   throttles new requests instead of dropping data.
//
//   Optional feature: define AXI_RD_BEAT_CNT_EN to build a saturating
//   completed-beat counter on rd_beat_cnt. Otherwise rd_beat_cnt is tied to 0.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   AR*  (ID/ADDR/LEN/SIZE/BURST/REGION/VALID/READY)   read address channel
//   R*   (ID/DATA/RESP/LAST/VALID/READY)               read data channel
//   axi_rd_vld/addr/region    internal read request, one beat per pulse
//   rd_data_vld/data/err      internal read return, 1 cycle after request
//   rd_beat_cnt               completed R beats (optional counter)

module axi_read_intf #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic [3:0]        ARREGION,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              axi_rd_vld,
  output logic [ADDR_W-1:0] axi_rd_addr,
  output logic [1:0]        axi_rd_region,
  input  logic              rd_data_vld,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_err,
  output logic [15:0]       rd_beat_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  state_t              state_q, state_d;
  logic                arready_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic                fixed_q;
  logic [1:0]          region_q;
  logic [1:0]          err_q;
  logic [7:0]          beat_q;
  logic                infl_q;
  logic                infl_last_q;

  logic [DATA_W-1:0]   buf_data [2];
  logic [1:0]          buf_resp [2];
  logic                buf_last [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          occ_q;

  logic                ar_hs, push, pop, issue, credit_ok, err_burst;
  logic [1:0]          occ_after_pop;
  logic [1:0]          ar_err;
  logic                unused_region_hi;

  assign unused_region_hi = ^ARREGION[3:2];

  assign err_burst = (err_q != RESP_OKAY);
  assign ar_hs     = ARVALID & arready_q;
  assign RVALID    = (occ_q != 2'd0);
  assign pop       = RVALID & RREADY;
  // Error bursts have no real read behind them; their beat is pushed on the
  // same schedule as a returned read so both burst kinds share the same timing.
  assign push      = infl_q & (err_burst | rd_data_vld);

  // A slot freed by this cycle's pop counts as free, so a steady RREADY=1
  // stream sustains one beat per cycle without ever exceeding two entries.
  assign occ_after_pop = occ_q - {1'b0, pop};
  assign credit_ok     = ({1'b0, occ_after_pop} + {2'b00, infl_q}) < 3'd2;
  assign issue         = (state_q == ISSUE) & credit_ok;

  assign ar_err = ((ARSIZE != 3'd2) || ARBURST[1]) ? RESP_SLVERR :
                  (ARREGION[1:0] == 2'd3)         ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = ISSUE;
      ISSUE:   if (issue && (beat_q == len_q)) state_d = DRAIN;
      DRAIN:   if (pop && buf_last[rd_ptr_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      fixed_q     <= 1'b0;
      region_q    <= '0;
      err_q       <= RESP_OKAY;
      beat_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        id_q     <= ARID;
        addr_q   <= ARADDR;
        len_q    <= ARLEN;
        fixed_q  <= (ARBURST == 2'd0);
        region_q <= ARREGION[1:0];
        err_q    <= ar_err;
        beat_q   <= '0;
      end else if (issue) begin
        beat_q <= beat_q + 8'd1;
        if (!fixed_q) addr_q <= addr_q + ADDR_W'(4);
      end
      infl_q      <= issue;
      infl_last_q <= (beat_q == len_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_resp[i] <= '0;
        buf_last[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr_q] <= err_burst ? '0 : rd_data;
        buf_resp[wr_ptr_q] <= err_burst ? err_q : (rd_err ? RESP_SLVERR : RESP_OKAY);
        buf_last[wr_ptr_q] <= infl_last_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign ARREADY       = arready_q;
  assign RID           = id_q;
  assign RDATA         = buf_data[rd_ptr_q];
  assign RRESP         = buf_resp[rd_ptr_q];
  assign RLAST         = buf_last[rd_ptr_q];
  assign axi_rd_vld    = issue & ~err_burst;
  assign axi_rd_addr   = addr_q;
  assign axi_rd_region = region_q;

`ifdef AXI_RD_BEAT_CNT_EN
  logic [15:0] beat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (pop && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign rd_beat_cnt = beat_cnt_q;
`else
  assign rd_beat_cnt = '0;
`endif

endmodule
